// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
//   Definitions shared by the UART receiver and transmitter:
//     - uart_state_t : frame state encoding (IDLE/START_BIT/DATA_BITS/
//                      PARITY_BIT/STOP_BIT)
//     - uart_cfg_t   : line-control bundle (PEN, EPS, SP, STB, WLS) held
//                      for the duration of one frame
//     - last_bit_idx : index of the final data bit for a given WLS
//     - parity_bit   : expected parity bit for a word and line setup
// ----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START_BIT  = 3'd1,
        DATA_BITS  = 3'd2,
        PARITY_BIT = 3'd3,
        STOP_BIT   = 3'd4
    } uart_state_t;

    typedef struct packed {
        logic       pen;
        logic       eps;
        logic       sp;
        logic       stb;
        logic [1:0] wls;
    } uart_cfg_t;

    // WLS 00 -> 6 bits, 01 -> 7 bits, 10/11 -> 8 bits
    function automatic logic [2:0] last_bit_idx(input logic [1:0] wls);
        case (wls)
            2'b00:   return 3'd5;
            2'b01:   return 3'd6;
            default: return 3'd7;
        endcase
    endfunction

    // Unused data bits must already be 0 so they do not disturb the XOR.
    function automatic logic parity_bit(input logic       pen,
                                        input logic       eps,
                                        input logic       sp,
                                        input logic [7:0] data);
        if (!pen) return 1'b0;
        if (sp)   return ~eps;
        if (eps)  return ^data;
        return ~^data;
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// ----------------------------------------------------------------------------
// uart_rx_sampler
//   Front end of the UART receiver: synchronises rx, runs the per-bit tick
//   counter and produces one decided bit value per bit period.
//
//   Ports
//     clk          in   oversample clock
//     rst_n        in   asynchronous active-low reset
//     i_rx         in   raw serial line
//     i_load       in   restart the tick counter on a detected start edge
//     i_run        in   a frame is being received (counter free-runs)
//     o_fall       out  1->0 transition seen on the synchronised line
//     o_bit_valid  out  one-cycle strobe, o_bit_val holds a new bit
//     o_bit_val    out  decided bit value
//
//   Configuration macro
//     UART_RX_MAJORITY_VOTE_EN : decide each bit by 2-of-3 vote over ticks
//                                mid-1, mid, mid+1; otherwise take the mid
//                                sample alone. The strobe timing is the same.
// ----------------------------------------------------------------------------
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_rx,
    input  logic i_load,
    input  logic i_run,
    output logic o_fall,
    output logic o_bit_valid,
    output logic o_bit_val
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    // Decision tick is mid+1 (mid = OVERSAMPLE/2-1) so all three vote
    // samples exist; the single-sample build decides at the same tick.
    localparam logic [TW-1:0] TICK_DECIDE = TW'(OVERSAMPLE / 2);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_d1;
    logic [TW-1:0]          r_tick;
    logic                   r_bit_valid;
    logic                   r_bit_val;
    logic                   w_rxs;
    logic                   w_sample;
    logic                   w_decide;

    assign w_rxs    = r_sync[SYNC_STAGES-1];
    assign w_decide = i_run && (r_tick == TICK_DECIDE);
    assign o_fall   = r_d1 & ~w_rxs;

`ifdef UART_RX_MAJORITY_VOTE_EN
    logic r_d2;

    // r_d2 = rxs at mid-1, r_d1 = rxs at mid, w_rxs = rxs at mid+1
    assign w_sample = (r_d2 & r_d1) | (r_d2 & w_rxs) | (r_d1 & w_rxs);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_d2 <= 1'b1;
        else        r_d2 <= r_d1;
    end
`else
    assign w_sample = r_d1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync      <= '1;
            r_d1        <= 1'b1;
            r_tick      <= '0;
            r_bit_valid <= 1'b0;
            r_bit_val   <= 1'b1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_rx};
            r_d1   <= w_rxs;

            // The edge cycle itself is tick 0, so the counter resumes at 1.
            if (i_load)
                r_tick <= TW'(1);
            else if (i_run)
                r_tick <= (r_tick == TICK_LAST) ? '0 : r_tick + 1'b1;
            else
                r_tick <= '0;

            r_bit_valid <= w_decide;
            if (w_decide)
                r_bit_val <= w_sample;
        end
    end

    assign o_bit_valid = r_bit_valid;
    assign o_bit_val   = r_bit_val;

endmodule

// File: rtl/uart8_receiver.sv
// ----------------------------------------------------------------------------
// uart8_receiver
//   Receive side of the 8-bit UART. Deserialises 6/7/8-bit words, checks
//   parity and stop bits, detects break and holds each word until read.
//
//   Ports
//     clk, rst_n             oversample clock, asynchronous active-low reset
//     rx                     serial line, idle high
//     PEN/EPS/SP/STB/WLS     line control, captured at each valid start bit
//     rd                     host read strobe, clears ready and oe
//     out[7:0]               received word, unused MSBs 0
//     ready                  word valid, held until rd
//     done                   one-cycle pulse at end of frame
//     busy                   frame in progress
//     pe / fe / bi           parity / framing / break status of word in out
//     oe                     overrun, sticky until rd
//
//   Configuration macro
//     UART_RX_MAJORITY_VOTE_EN : 2-of-3 majority bit decision (in sampler)
// ----------------------------------------------------------------------------
module uart8_receiver
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    input  logic       PEN,
    input  logic       EPS,
    input  logic       SP,
    input  logic       STB,
    input  logic [1:0] WLS,
    input  logic       rd,
    output logic [7:0] out,
    output logic       ready,
    output logic       done,
    output logic       busy,
    output logic       pe,
    output logic       fe,
    output logic       bi,
    output logic       oe
);

    uart_state_t r_state;
    uart_cfg_t   r_cfg;
    logic [7:0]  r_data;
    logic [2:0]  r_bitcnt;
    logic        r_stop_idx;
    logic        r_pe_acc;
    logic        r_fe_acc;
    logic        r_all_zero;
    logic [7:0]  r_out;
    logic        r_ready;
    logic        r_done;
    logic        r_busy;
    logic        r_pe;
    logic        r_fe;
    logic        r_bi;
    logic        r_oe;

    logic w_load;
    logic w_run;
    logic w_fall;
    logic w_bit_valid;
    logic w_bit_val;
    logic w_last_stop;
    logic w_frame_end;
    logic w_brk;

    assign w_load = (r_state == IDLE) && w_fall;
    assign w_run  = (r_state != IDLE);

    uart_rx_sampler #(
        .OVERSAMPLE  (OVERSAMPLE),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sampler (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_rx        (rx),
        .i_load      (w_load),
        .i_run       (w_run),
        .o_fall      (w_fall),
        .o_bit_valid (w_bit_valid),
        .o_bit_val   (w_bit_val)
    );

    assign w_last_stop = !r_cfg.stb || r_stop_idx;
    assign w_frame_end = (r_state == STOP_BIT) && w_bit_valid && w_last_stop;
    // Break: start, data, parity and every stop sample were all 0.
    assign w_brk       = r_all_zero & ~w_bit_val;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_cfg      <= '0;
            r_data     <= '0;
            r_bitcnt   <= '0;
            r_stop_idx <= 1'b0;
            r_pe_acc   <= 1'b0;
            r_fe_acc   <= 1'b0;
            r_all_zero <= 1'b0;
            r_out      <= '0;
            r_ready    <= 1'b0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
            r_pe       <= 1'b0;
            r_fe       <= 1'b0;
            r_bi       <= 1'b0;
            r_oe       <= 1'b0;
        end else begin
            r_done <= 1'b0;

            // A frame ending in the same cycle as rd wins for ready; the
            // read still clears any pending overrun.
            if (w_frame_end) begin
                r_ready <= 1'b1;
                r_oe    <= rd ? 1'b0 : (r_oe | r_ready);
            end else if (rd) begin
                r_ready <= 1'b0;
                r_oe    <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    // A fall edge only exists after the line has been high,
                    // which keeps a held break from re-arming the receiver.
                    if (w_fall)
                        r_state <= START_BIT;
                end

                START_BIT: begin
                    if (w_bit_valid) begin
                        if (w_bit_val) begin
                            r_state <= IDLE;
                        end else begin
                            r_cfg      <= '{pen: PEN, eps: EPS, sp: SP, stb: STB, wls: WLS};
                            r_busy     <= 1'b1;
                            r_data     <= '0;
                            r_bitcnt   <= '0;
                            r_stop_idx <= 1'b0;
                            r_pe_acc   <= 1'b0;
                            r_fe_acc   <= 1'b0;
                            r_all_zero <= 1'b1;
                            r_state    <= DATA_BITS;
                        end
                    end
                end

                DATA_BITS: begin
                    if (w_bit_valid) begin
                        r_data[r_bitcnt] <= w_bit_val;
                        r_all_zero       <= r_all_zero & ~w_bit_val;
                        if (r_bitcnt == last_bit_idx(r_cfg.wls))
                            r_state <= r_cfg.pen ? PARITY_BIT : STOP_BIT;
                        else
                            r_bitcnt <= r_bitcnt + 3'd1;
                    end
                end

                PARITY_BIT: begin
                    if (w_bit_valid) begin
                        r_pe_acc   <= (w_bit_val != parity_bit(r_cfg.pen, r_cfg.eps,
                                                               r_cfg.sp, r_data));
                        r_all_zero <= r_all_zero & ~w_bit_val;
                        r_state    <= STOP_BIT;
                    end
                end

                STOP_BIT: begin
                    if (w_bit_valid) begin
                        if (!w_bit_val)
                            r_fe_acc <= 1'b1;
                        r_all_zero <= r_all_zero & ~w_bit_val;
                        if (w_last_stop) begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_out   <= w_brk ? 8'h00 : r_data;
                            r_pe    <= r_pe_acc;
                            r_fe    <= r_fe_acc | ~w_bit_val;
                            r_bi    <= w_brk;
                        end else begin
                            r_stop_idx <= 1'b1;
                        end
                    end
                end

                default: r_state <= IDLE;
            endcase
        end
    end

    assign out   = r_out;
    assign ready = r_ready;
    assign done  = r_done;
    assign busy  = r_busy;
    assign pe    = r_pe;
    assign fe    = r_fe;
    assign bi    = r_bi;
    assign oe    = r_oe;

endmodule

// File: tb/tb_uart8_receiver.sv
// ----------------------------------------------------------------------------
// tb_uart8_receiver
//   Directed bench for uart8_receiver (OVERSAMPLE=16, SYNC_STAGES=2).
//   Frames are written as bit vectors, sent LSB first, 16 clocks per bit.
// ----------------------------------------------------------------------------
module tb_uart8_receiver;

    localparam int OS = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic       PEN, EPS, SP, STB;
    logic [1:0] WLS;
    logic       rd;
    logic [7:0] out;
    logic       ready, done, busy, pe, fe, bi, oe;

    int n_tests = 0;
    int n_fail  = 0;
    int done_total = 0;
    int d0;

    always #5 clk = ~clk;

    always @(posedge clk)
        if (done === 1'b1) done_total <= done_total + 1;

    uart8_receiver #(.OVERSAMPLE(OS), .SYNC_STAGES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rx    (rx),
        .PEN   (PEN),
        .EPS   (EPS),
        .SP    (SP),
        .STB   (STB),
        .WLS   (WLS),
        .rd    (rd),
        .out   (out),
        .ready (ready),
        .done  (done),
        .busy  (busy),
        .pe    (pe),
        .fe    (fe),
        .bi    (bi),
        .oe    (oe)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // bits[0] is sent first (start bit), each held for one bit period
    task automatic send_frame(input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            rx = bits[i];
            cycles(OS);
        end
        rx = 1'b1;
    endtask

    task automatic read_pulse();
        rd = 1'b1;
        cycles(1);
        rd = 1'b0;
        cycles(1);
    endtask

    task automatic cfg(input logic [1:0] wls, input logic pen, input logic eps,
                       input logic sp, input logic stb);
        WLS = wls; PEN = pen; EPS = eps; SP = sp; STB = stb;
    endtask

    initial begin
        rst_n = 1'b0;
        rx    = 1'b1;
        rd    = 1'b0;
        cfg(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        cycles(3);
        check("reset_outputs", {out, ready, done, busy, pe, fe, bi, oe}, 32'h0);
        rst_n = 1'b1;
        cycles(5);

        // 8N1, 0xA5
        d0 = done_total;
        send_frame({1'b1, 8'hA5, 1'b0}, 10);
        cycles(4);
        check("t1_out", out, 32'hA5);
        check("t1_done_pulses", done_total - d0, 1);
        check("t1_flags", {ready, pe, fe, bi, oe, busy, done}, 7'b1000000);
        read_pulse();
        check("t1_rd_clears_ready", ready, 0);

        // 7 bits, odd parity, 0x35 has four ones -> parity 1 expected, send 0
        cfg(2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
        cycles(2);
        d0 = done_total;
        send_frame({1'b1, 1'b0, 7'h35, 1'b0}, 10);
        cycles(4);
        check("t2_out", out, 32'h35);
        check("t2_pe", pe, 1);
        check("t2_fe_bi", {fe, bi}, 2'b00);
        check("t2_done_pulses", done_total - d0, 1);
        read_pulse();

        // 6 bits, stick parity (EPS=0 -> parity bit 1), two stops, second stop 0
        cfg(2'b00, 1'b1, 1'b0, 1'b1, 1'b1);
        cycles(2);
        d0 = done_total;
        send_frame({1'b0, 1'b1, 1'b1, 6'h2A, 1'b0}, 10);
        cycles(4);
        check("t3_out", out, 32'h2A);
        check("t3_fe", fe, 1);
        check("t3_pe_bi", {pe, bi}, 2'b00);
        check("t3_ready", ready, 1);
        read_pulse();

        // Glitch: 5 clocks low is shorter than half a bit
        cfg(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        cycles(2);
        d0 = done_total;
        rx = 1'b0;
        cycles(5);
        rx = 1'b1;
        cycles(3 * OS);
        check("t4_no_done", done_total - d0, 0);
        check("t4_busy_ready", {busy, ready}, 2'b00);

        // Two frames with no read -> overrun, second word kept
        d0 = done_total;
        send_frame({1'b1, 8'h11, 1'b0}, 10);
        cycles(2);
        check("t5_first_out", out, 32'h11);
        check("t5_first_oe", oe, 0);
        send_frame({1'b1, 8'h22, 1'b0}, 10);
        cycles(4);
        check("t5_out", out, 32'h22);
        check("t5_ready_oe", {ready, oe}, 2'b11);
        check("t5_done_pulses", done_total - d0, 2);
        read_pulse();
        check("t5_rd_clears", {ready, oe}, 2'b00);

        // Break: line low for two frame times
        d0 = done_total;
        rx = 1'b0;
        cycles(20 * OS);
        check("t6_break_flags", {out, bi, fe, ready}, {8'h00, 3'b111});
        check("t6_single_done", done_total - d0, 1);
        check("t6_not_busy", busy, 0);
        rx = 1'b1;
        cycles(2 * OS);
        read_pulse();
        check("t6_rearm_idle", {busy, ready}, 2'b00);

        // Normal frame after the break
        d0 = done_total;
        send_frame({1'b1, 8'h3C, 1'b0}, 10);
        cycles(4);
        check("t6_after_break_out", out, 32'h3C);
        check("t6_after_break_flags", {bi, fe, pe, ready}, 4'b0001);

        // Asynchronous reset in the middle of a frame
        rx = 1'b0;
        cycles(3 * OS);
        check("t7_busy_before_reset", busy, 1);
        rst_n = 1'b0;
        #1;
        check("t7_reset_outputs", {out, ready, done, busy, pe, fe, bi, oe}, 32'h0);
        cycles(2);
        rx = 1'b1;
        rst_n = 1'b1;
        cycles(3 * OS);
        check("t7_idle_after_reset", {busy, ready, done}, 3'b000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
